// File: rtl/ucseq_pkg.sv
// ucseq_pkg: shared types and constants for the microcode sequencer.
//   - state_t      : sequencer FSM states (IDLE, FETCH, EXEC)
//   - *_BIT / *_LSB: bit positions of the control-word fields
//   - calc_next_addr: next micro-PC given a take-target decision
// Optional feature macro: UCSEQ_LOOP_EN (loop counter support, see top).
package ucseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Control-word field positions. The target field starts at TARGET_LSB
  // and is UADDR_W wide; the passthrough ctrl bits sit above it.
  localparam int unsigned TYPE_LSB     = 0;
  localparam int unsigned TYPE_W       = 4;
  localparam int unsigned TJL_BIT      = 4;
  localparam int unsigned END_BIT      = 5;
  localparam int unsigned JMP_BIT      = 6;
  localparam int unsigned COND_SEL_BIT = 7;
  localparam int unsigned LOOP_BIT     = 8;
  localparam int unsigned TARGET_LSB   = 9;

  // Widest address the helper handles; callers truncate to UADDR_W.
  localparam int unsigned ADDR_MAX_W   = 32;

  // Returns target when take_target is set, otherwise upc+1. The result is
  // masked to aw bits so the increment wraps modulo 2^aw.
  function automatic logic [ADDR_MAX_W-1:0] calc_next_addr(
    input logic                  take_target,
    input logic [ADDR_MAX_W-1:0] upc,
    input logic [ADDR_MAX_W-1:0] target,
    input int unsigned           aw
  );
    logic [ADDR_MAX_W:0]   mask_w;
    logic [ADDR_MAX_W-1:0] mask;
    mask_w = (33'd1 << aw) - 33'd1;
    mask   = mask_w[ADDR_MAX_W-1:0];
    if (take_target) begin
      return target & mask;
    end
    return (upc + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/ucseq_next_addr.sv
// ucseq_next_addr: combinational next-address priority select.
// Ports:
//   w_end, w_loop, w_jmp, w_cond_sel : control-word flag bits of the word in EXEC
//   cond_in   : branch condition
//   lcnt_nz   : loop counter is non-zero (tie 0 when loops are not built)
//   upc       : current micro-PC
//   target    : target field of the word in EXEC
//   is_end    : word retires the instruction
//   loop_dec  : loop branch taken, loop counter must decrement
//   nxt_addr  : address of the next word (meaningless when is_end)
// Priority: end > loop (lcnt!=0) > jump (conditional or not) > upc+1.
module ucseq_next_addr
  import ucseq_pkg::*;
#(
  parameter int unsigned UADDR_W = 8
) (
  input  logic               w_end,
  input  logic               w_loop,
  input  logic               w_jmp,
  input  logic               w_cond_sel,
  input  logic               cond_in,
  input  logic               lcnt_nz,
  input  logic [UADDR_W-1:0] upc,
  input  logic [UADDR_W-1:0] target,
  output logic               is_end,
  output logic               loop_dec,
  output logic [UADDR_W-1:0] nxt_addr
);

  logic                  jmp_take;
  logic                  take_target;
  logic [ADDR_MAX_W-1:0] next_wide;
  logic                  unused_hi;

  assign is_end      = w_end;
  assign loop_dec    = !w_end && w_loop && lcnt_nz;
  assign jmp_take    = w_jmp && (!w_cond_sel || cond_in);
  assign take_target = loop_dec || (!w_end && jmp_take);

  assign next_wide = calc_next_addr(take_target, ADDR_MAX_W'(upc),
                                    ADDR_MAX_W'(target), UADDR_W);
  assign nxt_addr  = next_wide[UADDR_W-1:0];
  // Bits above UADDR_W are always zero after masking.
  assign unused_hi = ^next_wide[ADDR_MAX_W-1:UADDR_W];

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: fetches control words from control memory and walks a
// microprogram per accepted instruction, presenting each word to the decode
// stage for one EXEC cycle (longer when exec_stall holds it).
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   instr_valid/ready   : instruction handshake, start address instr_uaddr,
//                         loop count instr_loop
//   cmem_rd_en/addr     : control-memory read request
//   cmem_data           : read data, valid the cycle after cmem_rd_en
//   cond_in             : branch condition, sampled in a non-stalled EXEC
//   exec_stall          : hold the current word in EXEC
//   CW_type, test_jmp_ld, cw_ctrl, cw_valid : decoded word fields (zero
//                         outside EXEC)
//   busy, done          : program in flight / end-word retire pulse
// Handshake: an instruction transfers on a cycle where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE, so the
// offerer must hold instr_valid and instr_uaddr stable until then.
// Macro UCSEQ_LOOP_EN: builds the loop counter and honours the loop bit;
// without it instr_loop is ignored and the loop bit reads as 0.
module ucode_sequencer
  import ucseq_pkg::*;
#(
  parameter int unsigned UADDR_W = 8,
  parameter int unsigned CW_W    = 32,
  parameter int unsigned LOOP_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [UADDR_W-1:0]            instr_uaddr,
  input  logic [LOOP_W-1:0]             instr_loop,
  output logic                          cmem_rd_en,
  output logic [UADDR_W-1:0]            cmem_addr,
  input  logic [CW_W-1:0]               cmem_data,
  input  logic                          cond_in,
  input  logic                          exec_stall,
  output logic [3:0]                    CW_type,
  output logic                          test_jmp_ld,
  output logic [CW_W-(UADDR_W+9)-1:0]   cw_ctrl,
  output logic                          cw_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CTRL_LSB = TARGET_LSB + UADDR_W;

  state_t              state_q, state_d;
  logic [UADDR_W-1:0]  upc_q;
  logic [CW_W-1:0]     cw_q;

  logic                accept;
  logic                advance;
  logic                w_loop;
  logic                lcnt_nz;
  logic                is_end;
  logic                loop_dec;
  logic [UADDR_W-1:0]  nxt_addr;

  ucseq_next_addr #(
    .UADDR_W (UADDR_W)
  ) u_next_addr (
    .w_end      (cw_q[END_BIT]),
    .w_loop     (w_loop),
    .w_jmp      (cw_q[JMP_BIT]),
    .w_cond_sel (cw_q[COND_SEL_BIT]),
    .cond_in    (cond_in),
    .lcnt_nz    (lcnt_nz),
    .upc        (upc_q),
    .target     (cw_q[TARGET_LSB +: UADDR_W]),
    .is_end     (is_end),
    .loop_dec   (loop_dec),
    .nxt_addr   (nxt_addr)
  );

`ifdef UCSEQ_LOOP_EN
  logic [LOOP_W-1:0] lcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
    end else if (accept) begin
      lcnt_q <= instr_loop;
    end else if (advance && loop_dec) begin
      lcnt_q <= lcnt_q - LOOP_W'(1);
    end
  end

  assign w_loop  = cw_q[LOOP_BIT];
  assign lcnt_nz = |lcnt_q;
`else
  logic unused_loop;

  assign w_loop      = 1'b0;
  assign lcnt_nz     = 1'b0;
  assign unused_loop = ^{instr_loop, cw_q[LOOP_BIT]};
`endif

  // Next-state and read-request logic.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    cmem_rd_en  = 1'b0;
    cmem_addr   = '0;
    done        = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept     = 1'b1;
          cmem_rd_en = 1'b1;
          cmem_addr  = instr_uaddr;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (!exec_stall) begin
          if (is_end) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            advance    = 1'b1;
            cmem_rd_en = 1'b1;
            cmem_addr  = nxt_addr;
            state_d    = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      upc_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        upc_q <= instr_uaddr;
      end else if (advance) begin
        upc_q <= nxt_addr;
      end
      // Read data arrives in the FETCH cycle.
      if (state_q == FETCH) begin
        cw_q <= cmem_data;
      end
    end
  end

  // Decode-stage outputs are forced to zero outside EXEC.
  assign cw_valid    = (state_q == EXEC);
  assign CW_type     = cw_valid ? cw_q[TYPE_LSB +: TYPE_W] : 4'd0;
  assign test_jmp_ld = cw_valid ? cw_q[TJL_BIT] : 1'b0;
  assign cw_ctrl     = cw_valid ? cw_q[CW_W-1:CTRL_LSB] : '0;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: randomized and directed stimulus for ucode_sequencer.
// A reference model walks each microprogram over the bench's control memory
// and queues the expected read addresses and executed words; a monitor pops
// and compares whenever the DUT issues a read or presents a word.
module tb_ucode_sequencer;

  localparam int unsigned UADDR_W = 8;
  localparam int unsigned CW_W    = 32;
  localparam int unsigned LOOP_W  = 8;
  localparam int unsigned CTRL_W  = CW_W - (UADDR_W + 9);
  localparam int unsigned EXP_W   = 1 + CTRL_W + 1 + 4;
`ifdef UCSEQ_LOOP_EN
  localparam bit LOOP_ON = 1'b1;
`else
  localparam bit LOOP_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               instr_valid;
  logic               instr_ready;
  logic [UADDR_W-1:0] instr_uaddr;
  logic [LOOP_W-1:0]  instr_loop;
  logic               cmem_rd_en;
  logic [UADDR_W-1:0] cmem_addr;
  logic [CW_W-1:0]    cmem_data;
  logic               cond_in;
  logic               exec_stall;
  logic [3:0]         CW_type;
  logic               test_jmp_ld;
  logic [CTRL_W-1:0]  cw_ctrl;
  logic               cw_valid;
  logic               busy;
  logic               done;

  ucode_sequencer #(
    .UADDR_W (UADDR_W),
    .CW_W    (CW_W),
    .LOOP_W  (LOOP_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_uaddr (instr_uaddr),
    .instr_loop  (instr_loop),
    .cmem_rd_en  (cmem_rd_en),
    .cmem_addr   (cmem_addr),
    .cmem_data   (cmem_data),
    .cond_in     (cond_in),
    .exec_stall  (exec_stall),
    .CW_type     (CW_type),
    .test_jmp_ld (test_jmp_ld),
    .cw_ctrl     (cw_ctrl),
    .cw_valid    (cw_valid),
    .busy        (busy),
    .done        (done)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [CW_W-1:0]    mem [0:255];
  logic               cond_tab [0:255];
  logic [UADDR_W-1:0] last_addr = '0;

  always @(posedge clk) begin
    if (cmem_rd_en) begin
      cmem_data <= mem[cmem_addr];
      last_addr <= cmem_addr;
    end
  end

  // Condition is a fixed per-address property of the running program.
  assign cond_in = cond_tab[last_addr];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [EXP_W-1:0]   exp_q[$];
  logic [UADDR_W-1:0] exp_rd[$];
  logic [UADDR_W-1:0] trace[$];
  bit                 stall_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [CW_W-1:0] mkw(input int typ, input bit tjl, input bit e,
                                          input bit jmp, input bit cs, input bit lp,
                                          input int tgt, input int ctrl);
    logic [CW_W-1:0] w;
    w        = '0;
    w[3:0]   = 4'(typ);
    w[4]     = tjl;
    w[5]     = e;
    w[6]     = jmp;
    w[7]     = cs;
    w[8]     = lp;
    w[16:9]  = 8'(tgt);
    w[31:17] = 15'(ctrl);
    return w;
  endfunction

  function automatic logic [EXP_W-1:0] pack_exp(input logic [CW_W-1:0] w);
    return {w[5], w[31:17], w[4], w[3:0]};
  endfunction

  // Reference model: executes the microprogram word by word from the flow
  // rules. Returns 0 if no end word is reached within the step cap.
  function automatic bit build_trace(input logic [7:0] start, input logic [7:0] lc);
    logic [7:0]      a;
    logic [CW_W-1:0] w;
    int              l;
    a = start;
    l = int'(lc);
    trace.delete();
    for (int n = 0; n < 40; n++) begin
      w = mem[a];
      trace.push_back(a);
      if (w[5]) return 1'b1;
      if (LOOP_ON && w[8] && l != 0) begin
        l = l - 1;
        a = w[16:9];
      end else if (w[6] && (!w[7] || cond_tab[a])) begin
        a = w[16:9];
      end else begin
        a = a + 8'd1;
      end
    end
    return 1'b0;
  endfunction

  // ---------------- monitor ----------------
  logic             held_v = 1'b0;
  logic [EXP_W-2:0] held;

  always @(negedge clk) begin
    logic [EXP_W-1:0]   got;
    logic [EXP_W-1:0]   e;
    logic [UADDR_W-1:0] a;
    got = {done, cw_ctrl, test_jmp_ld, CW_type};
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (cmem_rd_en) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", 32'(cmem_addr), 32'hFFFF_FFFF);
        end else begin
          a = exp_rd.pop_front();
          check("rd_addr", 32'(cmem_addr), 32'(a));
        end
      end
      if (held_v) check("stall_hold", 32'({cw_valid, got[EXP_W-2:0]}), 32'({1'b1, held}));
      if (cw_valid && exec_stall) begin
        check("stall_no_done_rd", 32'({done, cmem_rd_en}), 32'd0);
      end else if (cw_valid) begin
        if (exp_q.size() == 0) begin
          check("word_unexpected", 32'(got), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("word", 32'(got), 32'(e));
        end
      end else begin
        check("idle_outputs_zero", 32'(got), 32'd0);
      end
      held_v = cw_valid && exec_stall;
      held   = got[EXP_W-2:0];
    end
  end

  // ---------------- stall driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall_rand) exec_stall = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    exec_stall  = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_rd.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic load_expected(input logic [7:0] start, input logic [7:0] lc);
    if (!build_trace(start, lc)) begin
      check("model_terminates", 32'd0, 32'd1);
    end
    foreach (trace[i]) begin
      exp_rd.push_back(trace[i]);
      exp_q.push_back(pack_exp(mem[trace[i]]));
    end
  endtask

  // Offer for one cycle; the DUT is idle whenever this is called.
  task automatic issue(input logic [7:0] start, input logic [7:0] lc);
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr_uaddr = start;
    instr_loop  = lc;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 800; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (n == 800) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      do_reset();
    end
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_queues_empty"}, 32'(exp_q.size() + exp_rd.size()), 32'd0);
    check({name, "_ready"}, 32'({instr_ready, busy}), 32'b10);
  endtask

  task automatic run_prog(input string name, input logic [7:0] start, input logic [7:0] lc);
    done_cnt = 0;
    load_expected(start, lc);
    issue(start, lc);
    wait_done(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] st;
    logic [7:0] lc;
    int         tries;
    instr_valid = 1'b0;
    instr_uaddr = '0;
    instr_loop  = '0;
    exec_stall  = 1'b0;
    cmem_data   = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]      = mkw(0, 0, 1, 0, 0, 0, 0, 0);
      cond_tab[i] = 1'b0;
    end
    do_reset();

    // Reset values.
    @(negedge clk);
    check("reset_ready_busy", 32'({instr_ready, busy, done, cw_valid, cmem_rd_en}), 32'b10000);
    check("reset_outputs", 32'({CW_type, test_jmp_ld, cw_ctrl}), 32'd0);

    // Single end word: latency and field presentation.
    mem[8'h10] = mkw(3, 1, 1, 0, 0, 0, 0, 16'h1234);
    done_cnt = 0;
    load_expected(8'h10, 8'd0);
    issue(8'h10, 8'd0);
    @(negedge clk);
    check("t1_fetch", 32'({cw_valid, busy}), 32'b01);
    @(negedge clk);
    check("t2_exec", 32'({cw_valid, CW_type, test_jmp_ld, done}), 32'({1'b1, 4'd3, 1'b1, 1'b1}));
    @(negedge clk);
    check("t3_idle", 32'({busy, instr_ready}), 32'b01);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Sequential three-word program.
    mem[8'h20] = mkw(1, 0, 0, 0, 0, 0, 0, 1);
    mem[8'h21] = mkw(2, 1, 0, 0, 0, 0, 0, 2);
    mem[8'h22] = mkw(5, 0, 1, 0, 0, 0, 0, 3);
    run_prog("seq3", 8'h20, 8'd0);

    // Conditional jump, both outcomes.
    mem[8'h30] = mkw(7, 0, 0, 1, 1, 0, 8'h50, 9);
    mem[8'h31] = mkw(8, 0, 1, 0, 0, 0, 0, 10);
    mem[8'h50] = mkw(9, 1, 1, 0, 0, 0, 0, 11);
    cond_tab[8'h30] = 1'b0;
    run_prog("cond0", 8'h30, 8'd0);
    cond_tab[8'h30] = 1'b1;
    run_prog("cond1", 8'h30, 8'd0);
    cond_tab[8'h30] = 1'b0;

    // Loop word repeated by the loop count (a single pass without the macro).
    mem[8'h40] = mkw(4, 0, 0, 0, 0, 1, 8'h40, 12);
    mem[8'h41] = mkw(6, 0, 1, 0, 0, 0, 0, 13);
    run_prog("loop2", 8'h40, 8'd2);

    // Address wrap from the top of control memory.
    mem[8'hFF] = mkw(10, 0, 0, 0, 0, 0, 8'h33, 14);
    mem[8'h00] = mkw(11, 1, 1, 0, 0, 0, 0, 15);
    run_prog("wrap", 8'hFF, 8'd0);

    // Directed four-cycle stall on the first word of a program.
    done_cnt = 0;
    load_expected(8'h20, 8'd0);
    issue(8'h20, 8'd0);
    @(posedge clk);
    #2 exec_stall = 1'b1;
    repeat (4) @(posedge clk);
    #2 exec_stall = 1'b0;
    wait_done("stall4");

    // Reset mid-program: returns to idle at once, no done.
    done_cnt = 0;
    load_expected(8'h20, 8'd0);
    issue(8'h20, 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_idle", 32'({busy, instr_ready, done, cw_valid}), 32'b0100);
    exp_q.delete();
    exp_rd.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    run_prog("after_rst", 8'h10, 8'd0);

    // Randomized programs with random stalls.
    stall_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tries = 0;
      do begin
        for (int i = 0; i < 256; i++) begin
          mem[i]      = CW_W'($urandom);
          mem[i][5]   = ($urandom_range(0, 4) == 0);
          cond_tab[i] = 1'($urandom_range(0, 1));
        end
        st = 8'($urandom_range(0, 255));
        lc = 8'($urandom_range(0, 3));
        tries++;
      end while (!build_trace(st, lc) && tries < 50);
      run_prog("random", st, lc);
    end
    stall_rand = 1'b0;
    exec_stall = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Microcode sequencer that fetches control words from the control memory and drives the instruction-type decode stage. On each accepted PIM instruction it walks a microprogram from a start address. For every fetched word it presents the 4-bit type field, the type-load strobe and the remaining control bits, and it resolves sequential, jump, conditional and loop flow until an end-marked word retires the instruction.

## Interface
Parameters:
- UADDR_W, 8, control-memory address width.
- CW_W, 32, control-word width; must be at least UADDR_W + 10.
- LOOP_W, 8, loop-counter width; used only when the loop feature is compiled in.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_valid  in  1  new instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_uaddr  in  UADDR_W  microprogram start address.
- instr_loop  in  LOOP_W  initial loop count; ignored without the macro.
- cmem_rd_en  out  1  control-memory read strobe.
- cmem_addr  out  UADDR_W  control-memory address.
- cmem_data  in  CW_W  read data, valid exactly 1 cycle after cmem_rd_en.
- cond_in  in  1  branch condition, sampled in EXEC.
- exec_stall  in  1  hold the current word in EXEC.
- CW_type  out  4  type field passed to the decode stage.
- test_jmp_ld  out  1  type-load strobe passed to the decode stage.
- cw_ctrl  out  CW_W-(UADDR_W+9)  passthrough control bits.
- cw_valid  out  1  outputs are valid this cycle.
- busy  out  1  a microprogram is in flight.
- done  out  1  one-cycle pulse when the end word retires.

## Operation
Control-word layout (UADDR_W=8):
- [3:0] type.
- [4] tjl.
- [5] end.
- [6] jmp.
- [7] cond_sel (0 = unconditional, 1 = jump only if cond_in=1).
- [8] loop.
- [16:9] target.
- [CW_W-1:17] ctrl.

State machine, with states IDLE, FETCH and EXEC:
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: upc <= instr_uaddr, lcnt <= instr_loop, cmem_rd_en=1 with cmem_addr=instr_uaddr, go to FETCH.
- FETCH: capture cmem_data into the cw register, go to EXEC.
- EXEC:
  - cw_valid=1.
  - CW_type=cw[3:0].
  - test_jmp_ld=cw[4].
  - cw_ctrl=cw[CW_W-1:17].
  - If exec_stall=1: remain in EXEC with all outputs held and no read issued.
  - Otherwise choose the next address by priority:
    1. end: go to IDLE and pulse done.
    2. loop with lcnt!=0: lcnt--, next=target.
    3. jmp and (!cond_sel or cond_in): next=target.
    4. Otherwise next=upc+1, wrapping modulo 2^UADDR_W.
  - For every case except end: issue a read at next, upc <= next, go to FETCH.
- Outside EXEC: CW_type=0, test_jmp_ld=0, cw_ctrl=0, cw_valid=0. In these cycles the decode stage therefore sees an all-zero type.
- busy = (state != IDLE).
- An instruction offered while busy is not accepted. instr_valid must hold until accepted.

## Timing
- Reset values:
  - state=IDLE, upc=0, lcnt=0, cw=0.
  - All outputs 0 except instr_ready=1.
- Latency from acceptance to the first cw_valid: 2 cycles (accept at T, FETCH at T+1, EXEC at T+2).
- Throughput: one word per 2 cycles when no stall is applied.
- done is asserted in the same cycle as the final EXEC, then the block is in IDLE the next cycle.
- A new instruction can be accepted in the cycle after done.
- cond_in is sampled only in the non-stalled EXEC cycle.
- Asserting rst_n=0 mid-program returns the block to IDLE immediately. No done pulse is produced and the in-flight read is discarded.
- upc=2^UADDR_W-1 with no jump: the next address is 0.

## Configuration
- UCSEQ_LOOP_EN, when defined:
  - The lcnt register and the loop bit are active.
  - lcnt is loaded from instr_loop and decremented on each taken loop branch.
- UCSEQ_LOOP_EN, when undefined:
  - No lcnt register is built and instr_loop is ignored.
  - Bit [8] is treated as 0, so flow is decided only by end/jmp/increment.

## Structure
- Package ucseq_pkg holds:
  - the state enum (IDLE, FETCH, EXEC);
  - the bit-position constants for each field (type, tjl, end, jmp, cond_sel, loop, target base);
  - a function that returns the next address.
- One natural sub-module, ucseq_next_addr: the combinational priority select for the next address and the loop-decrement enable.
- The FSM and registers stay in the top module.

## Test plan
- Reset, then instr_uaddr=0x10 where word 0x10 = type 3, tjl, end → cmem_addr=0x10 at T; at T+2 CW_type=3, test_jmp_ld=1, done=1; IDLE at T+3.
- Program at 0x20..0x22 with end at 0x22 → reads at 0x20, 0x21, 0x22 every 2 cycles; 3 cw_valid pulses; one done.
- Word at 0x30 with jmp, cond_sel, target=0x50: with cond_in=0 the next read is 0x31; with cond_in=1 the next read is 0x50.
- UCSEQ_LOOP_EN defined, instr_loop=2, word 0x40 with loop and target=0x40, 0x41 with end → 0x40 executes 3 times, then 0x41, then done.
- exec_stall=1 for 4 cycles in EXEC → outputs held unchanged and no cmem_rd_en during the stall; the sequence resumes afterwards.
- Start at 0xFF with no jump → the next read is 0x00; rst_n pulsed low mid-program → busy=0 and instr_ready=1 immediately, with no done.
